// File: rtl/ar_bank_if.sv
// ar_bank_if: per-core bus and shared data-memory handshake signals of the AR bank
interface ar_bank_if #(
  parameter int WIDTH  = 16,
  parameter int NCORES = 4
);
  localparam int CW = $clog2(NCORES);
  logic [NCORES*WIDTH-1:0] bin;
  logic [NCORES-1:0]       wr;
  logic [NCORES-1:0]       inc;
  logic [NCORES-1:0]       ldbus;
  logic [NCORES*WIDTH-1:0] bout;
  logic [NCORES-1:0]       mem_req;
  logic [NCORES-1:0]       mem_grant;
  logic [WIDTH-1:0]        dmaddr;
  logic                    dm_valid;
  logic                    dm_ready;
  logic [CW-1:0]           dm_core;
  modport master (
    output bin, wr, inc, ldbus, mem_req, dm_ready,
    input  bout, mem_grant, dmaddr, dm_valid, dm_core
  );
  modport slave (
    input  bin, wr, inc, ldbus, mem_req, dm_ready,
    output bout, mem_grant, dmaddr, dm_valid, dm_core
  );
endinterface

// File: rtl/ar_bank.sv
// ar_bank: per-core address registers with bus read-out and round-robin shared data-memory port
module ar_bank #(
  parameter int WIDTH  = 16,
  parameter int NCORES = 4,
  parameter int STEP   = 1
) (
  input logic     clk,
  input logic     rst,
  ar_bank_if.slave b
);
  localparam int CW = $clog2(NCORES);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] ar [NCORES];
  logic [CW-1:0]    last, sel, idx;
  // Address registers: write beats increment, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCORES; i++) ar[i] <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++)
        ar[i] <= b.wr[i] ? b.bin[i*WIDTH +: WIDTH] : b.inc[i] ? ar[i] + WIDTH'(STEP) : ar[i];
    end
  end
  // Registered bus read-out of the pre-update AR value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b.bout <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++)
        if (b.ldbus[i]) b.bout[i*WIDTH +: WIDTH] <= ar[i];
    end
  end
  // Round-robin pick: first requester after the last granted core
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NCORES; k >= 1; k--) begin
      idx = CW'((int'(last) + k) % NCORES);
      if (b.mem_req[idx]) sel = idx;
    end
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // FSM next state: leave IDLE on any request, leave ISSUE on accept
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((|b.mem_req) ? ISSUE : IDLE) : (b.dm_ready ? IDLE : ISSUE);
  end
  // Memory-port datapath: capture address on issue, pulse grant on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b.dmaddr    <= '0;
      b.dm_core   <= '0;
      b.dm_valid  <= 1'b0;
      b.mem_grant <= '0;
      last        <= CW'(NCORES - 1);
    end else begin
      b.mem_grant <= '0;
      if (state == IDLE && |b.mem_req) begin
        b.dmaddr   <= ar[sel];
        b.dm_core  <= sel;
        b.dm_valid <= 1'b1;
      end else if (state == ISSUE && b.dm_ready) begin
        b.dm_valid           <= 1'b0;
        b.mem_grant[b.dm_core] <= 1'b1;
        last                 <= b.dm_core;
      end
    end
  end
endmodule

// File: tb/tb_ar_bank.sv
// tb_ar_bank: directed vector and sequence checks for ar_bank
module tb_ar_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  ar_bank_if #(.WIDTH(16), .NCORES(4)) bi ();
  ar_bank #(.WIDTH(16), .NCORES(4), .STEP(1)) dut (.clk(clk), .rst(rst), .b(bi));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  wr;
    logic [3:0]  inc;
    logic [3:0]  ld;
    logic [63:0] bin;
    logic [63:0] bout;
  } vec_t;
  vec_t vt [9];
  logic [1:0]  rr_core [5];
  logic [15:0] rr_addr [5];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle_inputs();
    bi.wr = '0; bi.inc = '0; bi.ldbus = '0; bi.bin = '0; bi.mem_req = '0; bi.dm_ready = 1'b0;
  endtask
  initial begin
    vt[0] = '{4'b1111, 4'b0000, 4'b1111, 64'h4444_3333_2222_FFFF, 64'h0000_0000_0000_0000};
    vt[1] = '{4'b0000, 4'b0001, 4'b1111, 64'h0,                   64'h4444_3333_2222_FFFF};
    vt[2] = '{4'b0010, 4'b0010, 4'b0001, 64'h0000_0000_1234_0000, 64'h4444_3333_2222_0000};
    vt[3] = '{4'b0000, 4'b0000, 4'b0010, 64'h0,                   64'h4444_3333_1234_0000};
    vt[4] = '{4'b0100, 4'b0000, 4'b0000, 64'h0000_00A0_0000_0000, 64'h4444_3333_1234_0000};
    vt[5] = '{4'b0100, 4'b0000, 4'b0100, 64'h0000_0055_0000_0000, 64'h4444_00A0_1234_0000};
    vt[6] = '{4'b0000, 4'b0000, 4'b0100, 64'h0,                   64'h4444_0055_1234_0000};
    vt[7] = '{4'b0000, 4'b1111, 4'b0000, 64'h0,                   64'h4444_0055_1234_0000};
    vt[8] = '{4'b0000, 4'b0000, 4'b1111, 64'h0,                   64'h4445_0056_1235_0001};
    rr_core = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_addr = '{16'h0001, 16'h1235, 16'h0056, 16'h4445, 16'h0001};
    idle_inputs();
    bi.mem_req = 4'b1111;
    bi.wr = 4'b1111;
    bi.bin = 64'hFFFF_FFFF_FFFF_FFFF;
    bi.ldbus = 4'b1111;
    bi.dm_ready = 1'b1;
    tick();
    tick();
    chk("reset_bout", bi.bout, 64'h0);
    chk("reset_valid", {63'h0, bi.dm_valid}, 64'h0);
    chk("reset_grant", {60'h0, bi.mem_grant}, 64'h0);
    chk("reset_dmaddr", {48'h0, bi.dmaddr}, 64'h0);
    idle_inputs();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      bi.wr = vt[i].wr; bi.inc = vt[i].inc; bi.ldbus = vt[i].ld; bi.bin = vt[i].bin;
      tick();
      chk($sformatf("vec%0d_bout", i), bi.bout, vt[i].bout);
    end
    idle_inputs();
    bi.mem_req = 4'b1111;
    bi.dm_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr%0d_valid", k), {63'h0, bi.dm_valid}, 64'h1);
      chk($sformatf("rr%0d_core", k), {62'h0, bi.dm_core}, {62'h0, rr_core[k]});
      chk($sformatf("rr%0d_addr", k), {48'h0, bi.dmaddr}, {48'h0, rr_addr[k]});
      tick();
      chk($sformatf("rr%0d_grant", k), {60'h0, bi.mem_grant}, 64'h1 << rr_core[k]);
      chk($sformatf("rr%0d_drop", k), {63'h0, bi.dm_valid}, 64'h0);
    end
    idle_inputs();
    tick();
    tick();
    bi.wr = 4'b0010; bi.bin = 64'h0000_0000_0200_0000;
    tick();
    bi.wr = 4'b0000; bi.mem_req = 4'b0010;
    tick();
    bi.wr = 4'b0010; bi.bin = 64'h0000_0000_0300_0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d_addr", k), {48'h0, bi.dmaddr}, 64'h0200);
      chk($sformatf("stall%0d_valid", k), {63'h0, bi.dm_valid}, 64'h1);
      chk($sformatf("stall%0d_grant", k), {60'h0, bi.mem_grant}, 64'h0);
    end
    bi.wr = 4'b0000; bi.dm_ready = 1'b1;
    tick();
    chk("stall_grant", {60'h0, bi.mem_grant}, 64'h2);
    bi.mem_req = 4'b0000; bi.ldbus = 4'b0010;
    tick();
    chk("stall_pulse_end", {60'h0, bi.mem_grant}, 64'h0);
    chk("stall_ar1", {48'h0, bi.bout[31:16]}, 64'h0300);
    idle_inputs();
    bi.mem_req = 4'b1000;
    tick();
    chk("rst_issue_core", {62'h0, bi.dm_core}, 64'h3);
    chk("rst_issue_addr", {48'h0, bi.dmaddr}, 64'h4445);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {63'h0, bi.dm_valid}, 64'h0);
    chk("rst_async_addr", {48'h0, bi.dmaddr}, 64'h0);
    chk("rst_async_bout", bi.bout, 64'h0);
    bi.dm_ready = 1'b1;
    tick();
    chk("rst_no_grant", {60'h0, bi.mem_grant}, 64'h0);
    rst = 1'b0;
    bi.mem_req = 4'b1001;
    tick();
    chk("post_rst_core", {62'h0, bi.dm_core}, 64'h0);
    chk("post_rst_valid", {63'h0, bi.dm_valid}, 64'h1);
    tick();
    chk("post_rst_grant0", {60'h0, bi.mem_grant}, 64'h1);
    bi.mem_req = 4'b1000;
    tick();
    chk("post_rst_core3", {62'h0, bi.dm_core}, 64'h3);
    tick();
    chk("post_rst_grant3", {60'h0, bi.mem_grant}, 64'h8);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
